// File: rtl/vga_pattern_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_pkg
// Description : Shared types, bar colour ROM and colour helpers for the
//               raster timing / test-pattern generator.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pattern_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID   = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_BARS    = 2'd2,
        MODE_GRID    = 2'd3
    } mode_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Timing/coordinate bundle that travels unchanged through the pipeline
    typedef struct packed {
        logic        de;
        logic        hblank;
        logic        vblank;
        logic        hs;
        logic        vs;
        logic [11:0] x;
        logic [11:0] y;
    } out_t;

    typedef struct packed {
        out_t        t;
        logic        fs;
        logic        chk;
        logic        grid;
        logic [2:0]  bar;
    } s1_t;

    // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [7:0][23:0] BAR_ROM = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

    function automatic rgb_t bar_rgb(input logic [2:0] idx);
        return rgb_t'(BAR_ROM[idx]);
    endfunction

    function automatic rgb_t rgb332_expand(input logic [7:0] c);
        rgb_t e;
        e.r = {c[7:5], c[7:5], c[7:6]};
        e.g = {c[4:2], c[4:2], c[4:3]};
        e.b = {4{c[1:0]}};
        return e;
    endfunction

    function automatic out_t out_reset(input logic hs_idle, input logic vs_idle);
        out_t o;
        o        = '0;
        o.hblank = 1'b1;
        o.vblank = 1'b1;
        o.hs     = hs_idle;
        o.vs     = vs_idle;
        return o;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_raster_counter.sv
`default_nettype none
// ============================================================================
// Module      : vga_raster_counter
// Description : h/v raster counters with blank/sync decode and frame strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_raster_counter #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_pix,
    output logic [11:0] h,
    output logic [11:0] v,
    output logic        line_end,
    output logic        hblank,
    output logic        vblank,
    output logic        hs_act,
    output logic        vs_act,
    output logic        frame_latch
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    logic [11:0] h_q, h_d;
    logic [11:0] v_q, v_d;

    assign line_end = (h_q == 12'(H_TOTAL - 1));

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (ce_pix) begin
            if (line_end) begin
                h_d = '0;
                v_d = (v_q == 12'(V_TOTAL - 1)) ? '0 : v_q + 12'd1;
            end else begin
                h_d = h_q + 12'd1;
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h           = h_q;
    assign v           = v_q;
    assign hblank      = (h_q >= 12'(H_ACTIVE));
    assign vblank      = (v_q >= 12'(V_ACTIVE));
    assign hs_act      = (h_q >= 12'(H_ACTIVE + H_FP)) && (h_q < 12'(H_ACTIVE + H_FP + H_SYNC));
    // v only moves on the h wrap, so VS naturally switches at h = 0
    assign vs_act      = (v_q >= 12'(V_ACTIVE + V_FP)) && (v_q < 12'(V_ACTIVE + V_FP + V_SYNC));
    assign frame_latch = ce_pix && (h_q == '0) && (v_q == '0);

endmodule

`default_nettype wire

// File: rtl/vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_pattern_gen
// Description : Parametrised raster timing and four-mode test-pattern source
//               with a two-stage ce_pix-qualified output pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pattern_gen
    import vga_pattern_pkg::*;
#(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int HS_POL    = 0,
    parameter int VS_POL    = 0,
    parameter int CELL_LOG2 = 5
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ce_pix,
    input  logic [1:0]  mode,
    input  logic [7:0]  color,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        hblank,
    output logic        vblank,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        frame_start
);

    localparam int          BAR_W     = H_ACTIVE / 8;
    localparam logic        HS_ON     = (HS_POL != 0);
    localparam logic        VS_ON     = (VS_POL != 0);
    localparam logic [11:0] CELL_MASK = 12'((1 << CELL_LOG2) - 1);
    localparam out_t        OUT_RST   = out_reset(~HS_ON, ~VS_ON);
    localparam s1_t         S1_RST    = '{t: OUT_RST, fs: 1'b0, chk: 1'b0, grid: 1'b0, bar: 3'd0};

    logic [11:0] w_h, w_v;
    logic        w_line_end, w_hblank, w_vblank, w_hs_act, w_vs_act, w_frame_latch;
    logic        w_de;
    rgb_t        w_fg, w_bg;

    vga_raster_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_raster (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .ce_pix      (ce_pix),
        .h           (w_h),
        .v           (w_v),
        .line_end    (w_line_end),
        .hblank      (w_hblank),
        .vblank      (w_vblank),
        .hs_act      (w_hs_act),
        .vs_act      (w_vs_act),
        .frame_latch (w_frame_latch)
    );

    mode_e       mode_q, mode_d;
    logic [7:0]  color_q, color_d;
    logic [11:0] frame_cnt_q, frame_cnt_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic [11:0] bar_cnt_q, bar_cnt_d;
    s1_t         s1_q, s1_d;
    out_t        s2_q, s2_d;
    rgb_t        rgb_q, rgb_d;
    logic        frame_start_q, frame_start_d;

    assign w_de = ~(w_hblank | w_vblank);
    assign w_fg = rgb332_expand(color_q);
    assign w_bg = ~w_fg;

    // Frame shadow registers and the divider-free bar index tracking h
    always_comb begin
        mode_d      = mode_q;
        color_d     = color_q;
        frame_cnt_d = frame_cnt_q;
        bar_idx_d   = bar_idx_q;
        bar_cnt_d   = bar_cnt_q;
        if (w_frame_latch) begin
            mode_d      = mode_e'(mode);
            color_d     = color;
            frame_cnt_d = frame_cnt_q + 12'd1;
        end
        if (ce_pix) begin
            if (w_line_end) begin
                bar_idx_d = '0;
                bar_cnt_d = '0;
            end else if (bar_idx_q != 3'd7) begin
                if (bar_cnt_q == 12'(BAR_W - 1)) begin
                    bar_idx_d = bar_idx_q + 3'd1;
                    bar_cnt_d = '0;
                end else begin
                    bar_cnt_d = bar_cnt_q + 12'd1;
                end
            end
        end
    end

    // Stage 1: timing decode and per-pattern selectors. The grid uses the
    // post-latch frame count so pixel (0,0) already sees the new frame.
    always_comb begin
        s1_d = s1_q;
        if (ce_pix) begin
            s1_d.t.de     = w_de;
            s1_d.t.hblank = w_hblank;
            s1_d.t.vblank = w_vblank;
            s1_d.t.hs     = w_hs_act ? HS_ON : ~HS_ON;
            s1_d.t.vs     = w_vs_act ? VS_ON : ~VS_ON;
            s1_d.t.x      = w_de ? w_h : '0;
            s1_d.t.y      = w_de ? w_v : '0;
            s1_d.fs       = w_frame_latch;
            s1_d.chk      = w_h[CELL_LOG2] ^ w_v[CELL_LOG2];
            s1_d.grid     = (((w_h + frame_cnt_d) & CELL_MASK) == '0) || ((w_v & CELL_MASK) == '0);
            s1_d.bar      = bar_idx_q;
        end
    end

    // Stage 2: colour mux; frame_start is re-evaluated every clk_sys so it
    // stays a single-cycle pulse even with a sparse ce_pix.
    always_comb begin
        s2_d          = s2_q;
        rgb_d         = rgb_q;
        frame_start_d = 1'b0;
        if (ce_pix) begin
            s2_d          = s1_q.t;
            frame_start_d = s1_q.fs;
            rgb_d         = '0;
            if (s1_q.t.de) begin
                case (mode_q)
                    MODE_SOLID:   rgb_d = w_fg;
                    MODE_CHECKER: rgb_d = s1_q.chk ? w_bg : w_fg;
                    MODE_BARS:    rgb_d = bar_rgb(s1_q.bar);
                    MODE_GRID:    rgb_d = s1_q.grid ? w_fg : '0;
                    default:      rgb_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            mode_q        <= MODE_SOLID;
            color_q       <= 8'hFF;
            frame_cnt_q   <= '0;
            bar_idx_q     <= '0;
            bar_cnt_q     <= '0;
            s1_q          <= S1_RST;
            s2_q          <= OUT_RST;
            rgb_q         <= '0;
            frame_start_q <= 1'b0;
        end else begin
            mode_q        <= mode_d;
            color_q       <= color_d;
            frame_cnt_q   <= frame_cnt_d;
            bar_idx_q     <= bar_idx_d;
            bar_cnt_q     <= bar_cnt_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga_r       = rgb_q.r;
    assign vga_g       = rgb_q.g;
    assign vga_b       = rgb_q.b;
    assign vga_hs      = s2_q.hs;
    assign vga_vs      = s2_q.vs;
    assign vga_de      = s2_q.de;
    assign hblank      = s2_q.hblank;
    assign vblank      = s2_q.vblank;
    assign x           = s2_q.x;
    assign y           = s2_q.y;
    assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_pattern_gen
// Description : Scoreboard bench for vga_pattern_gen on a reduced raster
//               (84 x 46 total, 68 x 40 active).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_pattern_gen;

    localparam int H_ACTIVE = 68, H_FP = 4, H_SYNC = 8, H_BP = 4;
    localparam int V_ACTIVE = 40, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int FRAME_LEN = 84 * 46;
    localparam int WAIT_MAX  = 13000;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        ce_pix  = 1'b1;
    logic [1:0]  mode    = 2'd0;
    logic [7:0]  color   = 8'h1C;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        vga_hs, vga_vs, vga_de, hblank, vblank, frame_start;
    logic [11:0] x, y;

    vga_pattern_gen #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .HS_POL (0), .VS_POL (0), .CELL_LOG2 (5)
    ) dut (
        .clk_sys (clk_sys), .reset (reset), .ce_pix (ce_pix),
        .mode (mode), .color (color),
        .vga_r (vga_r), .vga_g (vga_g), .vga_b (vga_b),
        .vga_hs (vga_hs), .vga_vs (vga_vs), .vga_de (vga_de),
        .hblank (hblank), .vblank (vblank), .x (x), .y (y),
        .frame_start (frame_start)
    );

    always #5 clk_sys = ~clk_sys;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    typedef struct {
        int          frame;
        int          px;
        int          py;
        logic [23:0] rgb;
        string       name;
    } item_t;
    item_t sb[$];

    task automatic expect_px(input int f, input int px, input int py, input logic [23:0] rgb, input string name);
        item_t it;
        it.frame = f; it.px = px; it.py = py; it.rgb = rgb; it.name = name;
        sb.push_back(it);
    endtask

    // ---------------- ce_pix 1-of-3 generator ----------------
    bit ce_div = 1'b0;
    int div    = 0;
    initial forever begin
        @(negedge clk_sys);
        if (ce_div) begin
            ce_pix = (div == 0);
            div    = (div + 1) % 3;
        end
    end

    // ---------------- monitor ----------------
    int   frame_no = 0;
    bit   stat_req = 1'b0, meas_on = 1'b0;
    int   frame_len, de_cnt, vs_low, hs_run, hs_low_len, line_ctr, line_len, blank_nz;
    bit   hs_prev = 1'b1, fs_prev = 1'b0, ce_s, rst_s;
    int   grid_frame = 0, gother = 0;
    logic [67:0] gmask0 = '0, gmask1 = '0, gexp;

    always @(posedge clk_sys) begin
        ce_s  = ce_pix;
        rst_s = reset;
        #1;
        if (fs_prev) check("fs_width", frame_start, 1'b0);
        fs_prev = frame_start;
        if (rst_s) begin
            meas_on = 1'b0;
        end else if (ce_s) begin
            if (frame_start) begin
                frame_no++;
                check("fs_align", {vga_de, x, y}, {1'b1, 24'd0});
                while (sb.size() > 0 && sb[0].frame < frame_no) begin
                    checks++; failures++;
                    $display("FAIL sb_missed %s: pixel (%0d,%0d) never seen in frame %0d",
                             sb[0].name, sb[0].px, sb[0].py, sb[0].frame);
                    void'(sb.pop_front());
                end
                if (meas_on) begin
                    check("frame_len",    frame_len,  FRAME_LEN);
                    check("de_per_frame", de_cnt,     68 * 40);
                    check("hs_low_len",   hs_low_len, 8);
                    check("line_len",     line_len,   84);
                    check("vs_low_clks",  vs_low,     2 * 84);
                    check("blank_rgb_nz", blank_nz,   0);
                end
                if (grid_frame != 0 && frame_no == grid_frame + 2) begin
                    for (int i = 0; i < 67; i++) gexp[i] = gmask0[i+1];
                    gexp[67] = gmask0[36];
                    check("grid_scroll",   gmask1, gexp);
                    check("grid_has_col",  (gmask0 != '0), 1'b1);
                    check("grid_bg_black", gother, 0);
                    grid_frame = 0;
                end
                meas_on   = stat_req;
                stat_req  = 1'b0;
                frame_len = 0; de_cnt = 0; vs_low = 0; blank_nz = 0;
            end
            frame_len++;
            if (vga_de) de_cnt++;
            if (!vga_vs) vs_low++;
            if (!vga_de && {vga_r, vga_g, vga_b} != 24'd0) blank_nz++;
            if (!vga_hs) hs_run++;
            else if (hs_run != 0) begin hs_low_len = hs_run; hs_run = 0; end
            if (hs_prev && !vga_hs) begin line_len = line_ctr; line_ctr = 1; end
            else line_ctr++;
            hs_prev = vga_hs;
            if (vga_de && sb.size() > 0 && frame_no == sb[0].frame &&
                int'(x) == sb[0].px && int'(y) == sb[0].py) begin
                check(sb[0].name, {vga_r, vga_g, vga_b}, sb[0].rgb);
                void'(sb.pop_front());
            end
            if (grid_frame != 0 && vga_de && y == 12'd1 &&
                (frame_no == grid_frame || frame_no == grid_frame + 1)) begin
                if ({vga_r, vga_g, vga_b} == 24'hFFFFFF) begin
                    if (frame_no == grid_frame) gmask0[x] = 1'b1;
                    else                        gmask1[x] = 1'b1;
                end else if ({vga_r, vga_g, vga_b} != 24'd0) begin
                    gother++;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_frame(input int n);
        int cyc = 0;
        while (frame_no < n && cyc < WAIT_MAX) begin @(negedge clk_sys); cyc++; end
        if (frame_no < n) begin
            checks++; failures++;
            $display("FAIL wait_frame: frame_no=%0d required=%0d", frame_no, n);
        end
        @(negedge clk_sys);
    endtask

    task automatic wait_pix(input int px, input int py);
        int cyc = 0;
        while (!(vga_de && (px < 0 || int'(x) == px) && int'(y) == py) && cyc < WAIT_MAX) begin
            @(negedge clk_sys); cyc++;
        end
        if (cyc >= WAIT_MAX) begin
            checks++; failures++;
            $display("FAIL wait_pix: (%0d,%0d) not reached", px, py);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_rgb",   {vga_r, vga_g, vga_b}, 24'd0);
        check("rst_de",    vga_de, 1'b0);
        check("rst_blank", {hblank, vblank}, 2'b11);
        check("rst_sync",  {vga_hs, vga_vs}, 2'b11);
        check("rst_fs",    frame_start, 1'b0);
        check("rst_xy",    {x, y}, 24'd0);
    endtask

    initial begin
        // Reset and solid-mode free run at ce_pix = 1
        repeat (3) @(posedge clk_sys);
        #1 check_reset_outputs();
        @(negedge clk_sys);
        stat_req = 1'b1;
        expect_px(1, 0, 0,   24'h00FF00, "solid_0_0");
        expect_px(1, 67, 39, 24'h00FF00, "solid_67_39");
        reset = 1'b0;
        wait_frame(2);

        // Checker, colour E0: FG red, BG cyan
        mode = 2'd1; color = 8'hE0;
        expect_px(3, 31, 0,  24'hFF0000, "chk_31_0");
        expect_px(3, 32, 0,  24'h00FFFF, "chk_32_0");
        expect_px(3, 64, 0,  24'hFF0000, "chk_64_0");
        expect_px(3, 0, 32,  24'h00FFFF, "chk_0_32");
        expect_px(3, 32, 32, 24'hFF0000, "chk_32_32");
        wait_frame(4);

        // Solid frame, then switch to bars mid-frame
        mode = 2'd0;
        wait_frame(5);
        wait_pix(-1, 10);
        mode = 2'd2;
        expect_px(5, 0, 20,  24'hFF0000, "midframe_solid_0_20");
        expect_px(5, 40, 39, 24'hFF0000, "midframe_solid_40_39");
        expect_px(6, 0, 0,   24'hFFFFFF, "bar_white_0");
        expect_px(6, 7, 0,   24'hFFFFFF, "bar_white_7");
        expect_px(6, 8, 0,   24'hFFFF00, "bar_yellow_8");
        expect_px(6, 16, 0,  24'h00FFFF, "bar_cyan_16");
        expect_px(6, 24, 0,  24'h00FF00, "bar_green_24");
        expect_px(6, 32, 0,  24'hFF00FF, "bar_magenta_32");
        expect_px(6, 40, 0,  24'hFF0000, "bar_red_40");
        expect_px(6, 48, 0,  24'h0000FF, "bar_blue_48");
        expect_px(6, 55, 1,  24'h0000FF, "bar_blue_55");
        expect_px(6, 56, 1,  24'h000000, "bar_black_56");
        expect_px(6, 67, 2,  24'h000000, "bar_remainder_67");
        wait_frame(7);

        // Scrolling grid, white foreground
        mode = 2'd3; color = 8'hFF;
        grid_frame = 8;
        expect_px(8, 5, 0,  24'hFFFFFF, "grid_row_5_0");
        expect_px(8, 5, 32, 24'hFFFFFF, "grid_row_5_32");
        wait_frame(10);

        // Reset mid-frame at counter (40,20) with ce_pix low
        wait_pix(38, 20);
        reset = 1'b1; ce_pix = 1'b0;
        @(posedge clk_sys);
        #1 check_reset_outputs();
        @(negedge clk_sys);
        reset = 1'b0; ce_pix = 1'b1;
        @(posedge clk_sys);
        #1 check("de_after_rst_1", vga_de, 1'b0);
        @(posedge clk_sys);
        #1 check("de_after_rst_2", {vga_de, x, y, frame_start}, {1'b1, 24'd0, 1'b1});

        // Decimated ce_pix: same checker image and raster counts in ce cycles
        @(negedge clk_sys);
        mode = 2'd1; color = 8'hE0; ce_div = 1'b1;
        stat_req = 1'b1;
        expect_px(12, 31, 0,  24'hFF0000, "dec_chk_31_0");
        expect_px(12, 32, 0,  24'h00FFFF, "dec_chk_32_0");
        expect_px(12, 32, 32, 24'hFF0000, "dec_chk_32_32");
        wait_frame(12);
        stat_req = 1'b1;
        wait_frame(13);
        repeat (4) @(negedge clk_sys);

        while (sb.size() > 0) begin
            checks++; failures++;
            $display("FAIL sb_unmatched %s: pixel (%0d,%0d) frame %0d",
                     sb[0].name, sb[0].px, sb[0].py, sb[0].frame);
            void'(sb.pop_front());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
